if_fetch_unit: RTL

//  Instruction-fetch stage that owns the program counter and feeds decode.

---
 rtl/if_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC owner, imem req/ack, decode valid/ready, redirect squash
// Optional feature macro: IF_PERF_EN (adds perf_fetch_cnt / perf_stall_cnt outputs)
module if_fetch_unit #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_PC  = 32'h00000010,
  parameter logic [N-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc_plus4
`ifdef IF_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] drop_addr_q, drop_addr_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_pc_q, out_pc_d;
  logic [N-1:0] out_instr_q, out_instr_d;
  logic [N-1:0] out_pc_plus4_q, out_pc_plus4_d;

  logic         consume;
  logic [N-1:0] redirect_target;
  logic [N-1:0] pc_plus4;

  assign consume         = out_valid_q && out_ready && en;
  assign redirect_target = {redirect_pc[N-1:2], 2'b00};
  assign pc_plus4        = pc_q + N'(4);

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_instr    = out_instr_q;
  assign out_pc_plus4 = out_pc_plus4_q;

  // Memory-side outputs: a request stays up (and its address stable) until acked, even after a redirect.
  always_comb begin
    imem_req  = ((state_q == S_FETCH) || (state_q == S_DROP)) && !reset;
    imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  end

  // Next-state logic: redirect outranks fetch completion and consume; acks outside a request are ignored.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_addr_d    = drop_addr_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_instr_d    = out_instr_q;
    out_pc_plus4_d = out_pc_plus4_q;

    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!imem_ack) begin
            // Outstanding request cannot be withdrawn; remember where it went and eat its reply.
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end
        S_HOLD:  state_d = S_FETCH;
        S_DROP:  if (imem_ack) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            out_pc_d       = pc_q;
            out_instr_d    = imem_rdata;
            out_pc_plus4_d = pc_plus4;
            out_valid_d    = 1'b1;
            pc_d           = pc_plus4;
            state_d        = S_HOLD;
          end
        end
        S_HOLD: begin
          if (consume) begin
            out_valid_d = 1'b0;
            state_d     = S_FETCH;
          end
        end
        S_DROP:  if (imem_ack) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_FETCH;
      pc_q           <= RESET_PC;
      drop_addr_q    <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_instr_q    <= NOP_INSTR;
      out_pc_plus4_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      drop_addr_q    <= drop_addr_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_instr_q    <= out_instr_d;
      out_pc_plus4_q <= out_pc_plus4_d;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;

  // Handoff and back-pressure counters; free-running, wrap naturally, independent of redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (consume)                  perf_fetch_q <= perf_fetch_q + 32'd1;
      if (out_valid_q && !consume)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end
`endif

endmodule
